// File: rtl/pipeline_if_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings, PC step
// and the bubble word.
package pipeline_if_pkg;

  typedef enum logic [1:0] {
    IF_S_REQ   = 2'd0,
    IF_S_HOLD  = 2'd1,
    IF_S_DRAIN = 2'd2
  } if_state_e;

  localparam logic [31:0] IF_PC_STEP  = 32'd4;
  localparam logic [31:0] IF_NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + IF_PC_STEP;
  endfunction

endpackage

// File: rtl/pipeline_if_if.sv
// Fetch-stage bus: instruction-memory request/ack pair plus the inst/pc pair
// handed to decode.
interface pipeline_if_if;
  // imem_req_o marks a request on imem_addr_o; the address is held until the
  // cycle imem_ack_i is seen high at a posedge, and imem_data_i is valid in
  // that same cycle. Only one request is ever outstanding.
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;

  modport master (
    output imem_req_o, imem_addr_o, inst_o, pc_o,
    input  imem_ack_i, imem_data_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, inst_o, pc_o,
    output imem_ack_i, imem_data_i
  );
endinterface

// File: rtl/pipeline_if.sv
// Instruction-fetch stage: owns the fetch PC, a single-outstanding imem
// handshake and a one-entry hold buffer for decode stalls and branch redirects.
module pipeline_if
  import pipeline_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter logic [31:0] NOP_INST = IF_NOP_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       stall_i,
  input  logic [4:0]       flush_i,
  input  logic             branch_e_i,
  input  logic [31:0]      branch_addr_i,
  output logic             stall_o,
  output if_state_e        state_o,
  pipeline_if_if.master    bus
);

  if_state_e   r_state;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_buf_valid;
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_pc;
  logic [31:0] r_target;

  logic        w_hold;
  logic        w_flush;
  logic        w_ack;
  logic        w_in_flight;
  logic [31:0] w_target;
  logic        w_unused;

  assign w_hold      = stall_i[0] | stall_i[1];
  assign w_flush     = flush_i[0];
  // An ack only counts while a request is actually being driven.
  assign w_ack       = bus.imem_ack_i & r_req;
  assign w_in_flight = r_req & ~w_ack;
  assign w_target    = {branch_addr_i[31:2], 2'b00};
  assign w_unused    = ^{stall_i[4:2], flush_i[4:1], branch_addr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IF_S_REQ;
      r_req       <= 1'b0;
      r_addr      <= RESET_PC;
      r_inst      <= NOP_INST;
      r_pc        <= ZERO_WORD;
      r_buf_valid <= 1'b0;
      r_buf_inst  <= NOP_INST;
      r_buf_pc    <= ZERO_WORD;
      r_target    <= RESET_PC;
    end else if (branch_e_i) begin
      r_inst      <= NOP_INST;
      r_buf_valid <= 1'b0;
      r_target    <= w_target;
      r_req       <= 1'b1;
      // A request still waiting for its ack must be drained before redirecting.
      if (w_in_flight) begin
        r_state <= IF_S_DRAIN;
      end else begin
        r_addr  <= w_target;
        r_state <= IF_S_REQ;
      end
    end else begin
      case (r_state)
        IF_S_REQ: begin
          r_req <= 1'b1;
          if (w_ack && (w_hold || w_flush)) begin
            r_buf_inst  <= bus.imem_data_i;
            r_buf_pc    <= r_addr;
            r_buf_valid <= 1'b1;
            r_state     <= IF_S_HOLD;
            r_req       <= 1'b0;
            if (!w_hold) r_inst <= NOP_INST;
          end else if (w_ack) begin
            r_inst <= bus.imem_data_i;
            r_pc   <= r_addr;
            r_addr <= pc_next(r_addr);
          end else if (!w_hold) begin
            r_inst <= NOP_INST;
          end
        end
        IF_S_HOLD: begin
          if (!w_hold && w_flush) begin
            r_inst <= NOP_INST;
          end else if (!w_hold) begin
            r_inst      <= r_buf_valid ? r_buf_inst : NOP_INST;
            r_pc        <= r_buf_pc;
            r_addr      <= pc_next(r_buf_pc);
            r_buf_valid <= 1'b0;
            r_state     <= IF_S_REQ;
            r_req       <= 1'b1;
          end
        end
        IF_S_DRAIN: begin
          r_inst <= NOP_INST;
          if (w_ack) begin
            r_addr  <= r_target;
            r_state <= IF_S_REQ;
          end
        end
        default: r_state <= IF_S_REQ;
      endcase
    end
  end

  assign bus.imem_req_o  = r_req;
  assign bus.imem_addr_o = r_addr;
  assign bus.inst_o      = r_inst;
  assign bus.pc_o        = r_pc;
  assign stall_o         = ((r_state == IF_S_REQ) & ~w_ack) | (r_state == IF_S_DRAIN);
  assign state_o         = r_state;

endmodule

// File: tb/tb_pipeline_if.sv
// Directed bench for the fetch stage: reset, streaming, slow memory, decode
// hold, branch drain/redirect and flush, checked against hand-derived values.
module tb_pipeline_if;
  import pipeline_if_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [4:0]  stall_i;
  logic [4:0]  flush_i;
  logic        branch_e_i;
  logic [31:0] branch_addr_i;
  logic        stall_o;
  if_state_e   state_o;
  int          n_checks;
  int          n_errors;

  pipeline_if_if u_bus ();

  pipeline_if #(.RESET_PC(32'h0), .NOP_INST(NOP)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .branch_e_i    (branch_e_i),
    .branch_addr_i (branch_addr_i),
    .stall_o       (stall_o),
    .state_o       (state_o),
    .bus           (u_bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    // not used as a shared check helper; kept empty of comparisons
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (u_bus.inst_o !== NOP) begin n_errors++; $display("FAIL rst_inst: got %h exp %h", u_bus.inst_o, NOP); end
    n_checks++; if (u_bus.pc_o !== 32'h0) begin n_errors++; $display("FAIL rst_pc: got %h exp %h", u_bus.pc_o, 32'h0); end
    n_checks++; if (u_bus.imem_req_o !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %b exp 0", u_bus.imem_req_o); end
    n_checks++; if (u_bus.imem_addr_o !== 32'h0) begin n_errors++; $display("FAIL rst_addr: got %h exp 0", u_bus.imem_addr_o); end
    n_checks++; if (state_o !== IF_S_REQ) begin n_errors++; $display("FAIL rst_state: got %0d exp %0d", state_o, IF_S_REQ); end
    rst = 1'b0;
    tick();
    n_checks++; if (u_bus.imem_req_o !== 1'b1) begin n_errors++; $display("FAIL first_req: got %b exp 1", u_bus.imem_req_o); end
    n_checks++; if (u_bus.imem_addr_o !== 32'h0) begin n_errors++; $display("FAIL first_addr: got %h exp 0", u_bus.imem_addr_o); end
  endtask

  task automatic test_stream();
    logic [31:0] words [3];
    words[0] = 32'h0010_0093; words[1] = 32'h0020_0113; words[2] = 32'h0030_0193;
    u_bus.imem_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      u_bus.imem_data_i = words[i];
      #1;
      n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL stream_stall[%0d]: got %b exp 0", i, stall_o); end
      tick();
      n_checks++; if (u_bus.inst_o !== words[i]) begin n_errors++; $display("FAIL stream_inst[%0d]: got %h exp %h", i, u_bus.inst_o, words[i]); end
      n_checks++; if (u_bus.pc_o !== 32'(4 * i)) begin n_errors++; $display("FAIL stream_pc[%0d]: got %h exp %h", i, u_bus.pc_o, 32'(4 * i)); end
    end
    u_bus.imem_ack_i = 1'b0;
    n_checks++; if (u_bus.imem_addr_o !== 32'hC) begin n_errors++; $display("FAIL stream_addr: got %h exp c", u_bus.imem_addr_o); end
  endtask

  task automatic restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ack_delay();
    restart();
    u_bus.imem_ack_i = 1'b1; u_bus.imem_data_i = 32'h0010_0093;
    tick();
    u_bus.imem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL delay_stall[%0d]: got %b exp 1", i, stall_o); end
      tick();
      n_checks++; if (u_bus.imem_addr_o !== 32'h4) begin n_errors++; $display("FAIL delay_addr[%0d]: got %h exp 4", i, u_bus.imem_addr_o); end
      n_checks++; if (u_bus.inst_o !== NOP) begin n_errors++; $display("FAIL delay_inst[%0d]: got %h exp %h", i, u_bus.inst_o, NOP); end
    end
    u_bus.imem_ack_i = 1'b1; u_bus.imem_data_i = 32'h0020_0113;
    tick();
    u_bus.imem_ack_i = 1'b0;
    n_checks++; if (u_bus.inst_o !== 32'h0020_0113) begin n_errors++; $display("FAIL delay_inst_done: got %h exp 00200113", u_bus.inst_o); end
    n_checks++; if (u_bus.pc_o !== 32'h4) begin n_errors++; $display("FAIL delay_pc_done: got %h exp 4", u_bus.pc_o); end
  endtask

  task automatic test_hold();
    stall_i = 5'b00010;
    u_bus.imem_ack_i = 1'b1; u_bus.imem_data_i = 32'h0030_0193;
    tick();
    u_bus.imem_ack_i = 1'b0;
    #1;
    n_checks++; if (state_o !== IF_S_HOLD) begin n_errors++; $display("FAIL hold_state: got %0d exp %0d", state_o, IF_S_HOLD); end
    n_checks++; if (u_bus.imem_req_o !== 1'b0) begin n_errors++; $display("FAIL hold_req: got %b exp 0", u_bus.imem_req_o); end
    n_checks++; if (u_bus.inst_o !== 32'h0020_0113) begin n_errors++; $display("FAIL hold_inst: got %h exp 00200113", u_bus.inst_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_errors++; $display("FAIL hold_stall_o: got %b exp 0", stall_o); end
    tick();
    n_checks++; if (u_bus.pc_o !== 32'h4) begin n_errors++; $display("FAIL hold_pc2: got %h exp 4", u_bus.pc_o); end
    n_checks++; if (u_bus.imem_req_o !== 1'b0) begin n_errors++; $display("FAIL hold_req2: got %b exp 0", u_bus.imem_req_o); end
    stall_i = 5'b0;
    tick();
    n_checks++; if (u_bus.inst_o !== 32'h0030_0193) begin n_errors++; $display("FAIL hold_release_inst: got %h exp 00300193", u_bus.inst_o); end
    n_checks++; if (u_bus.pc_o !== 32'h8) begin n_errors++; $display("FAIL hold_release_pc: got %h exp 8", u_bus.pc_o); end
    n_checks++; if (u_bus.imem_addr_o !== 32'hC) begin n_errors++; $display("FAIL hold_release_addr: got %h exp c", u_bus.imem_addr_o); end
    n_checks++; if (u_bus.imem_req_o !== 1'b1) begin n_errors++; $display("FAIL hold_release_req: got %b exp 1", u_bus.imem_req_o); end
  endtask

  task automatic test_branch_drain();
    branch_e_i = 1'b1; branch_addr_i = 32'h0000_0103;
    tick();
    branch_e_i = 1'b0; branch_addr_i = 32'h0;
    #1;
    n_checks++; if (state_o !== IF_S_DRAIN) begin n_errors++; $display("FAIL drain_state: got %0d exp %0d", state_o, IF_S_DRAIN); end
    n_checks++; if (u_bus.inst_o !== NOP) begin n_errors++; $display("FAIL drain_inst: got %h exp %h", u_bus.inst_o, NOP); end
    n_checks++; if (stall_o !== 1'b1) begin n_errors++; $display("FAIL drain_stall_o: got %b exp 1", stall_o); end
    tick();
    n_checks++; if (u_bus.imem_addr_o !== 32'hC) begin n_errors++; $display("FAIL drain_addr_held: got %h exp c", u_bus.imem_addr_o); end
    u_bus.imem_ack_i = 1'b1; u_bus.imem_data_i = 32'hDEAD_BEEF;
    tick();
    n_checks++; if (u_bus.inst_o !== NOP) begin n_errors++; $display("FAIL drain_drop: got %h exp %h", u_bus.inst_o, NOP); end
    n_checks++; if (u_bus.imem_addr_o !== 32'h100) begin n_errors++; $display("FAIL drain_target: got %h exp 100", u_bus.imem_addr_o); end
    n_checks++; if (u_bus.pc_o !== 32'h8) begin n_errors++; $display("FAIL drain_pc: got %h exp 8", u_bus.pc_o); end
    u_bus.imem_data_i = 32'h0040_0213;
    tick();
    u_bus.imem_ack_i = 1'b0;
    n_checks++; if (u_bus.inst_o !== 32'h0040_0213) begin n_errors++; $display("FAIL drain_next_inst: got %h exp 00400213", u_bus.inst_o); end
    n_checks++; if (u_bus.pc_o !== 32'h100) begin n_errors++; $display("FAIL drain_next_pc: got %h exp 100", u_bus.pc_o); end
  endtask

  task automatic test_ack_hold_branch();
    u_bus.imem_ack_i = 1'b1; u_bus.imem_data_i = 32'hCAFE_F00D;
    stall_i = 5'b00010; branch_e_i = 1'b1; branch_addr_i = 32'h0000_0200;
    tick();
    u_bus.imem_ack_i = 1'b0; stall_i = 5'b0; branch_e_i = 1'b0;
    n_checks++; if (state_o !== IF_S_REQ) begin n_errors++; $display("FAIL ahb_state: got %0d exp %0d", state_o, IF_S_REQ); end
    n_checks++; if (u_bus.inst_o !== NOP) begin n_errors++; $display("FAIL ahb_inst: got %h exp %h", u_bus.inst_o, NOP); end
    n_checks++; if (u_bus.imem_addr_o !== 32'h200) begin n_errors++; $display("FAIL ahb_addr: got %h exp 200", u_bus.imem_addr_o); end
    n_checks++; if (u_bus.imem_req_o !== 1'b1) begin n_errors++; $display("FAIL ahb_req: got %b exp 1", u_bus.imem_req_o); end
    tick();
    n_checks++; if (u_bus.inst_o !== NOP) begin n_errors++; $display("FAIL ahb_no_buffer: got %h exp %h", u_bus.inst_o, NOP); end
    u_bus.imem_ack_i = 1'b1; u_bus.imem_data_i = 32'h0050_0293;
    tick();
    u_bus.imem_ack_i = 1'b0;
    n_checks++; if (u_bus.inst_o !== 32'h0050_0293) begin n_errors++; $display("FAIL ahb_next_inst: got %h exp 00500293", u_bus.inst_o); end
    n_checks++; if (u_bus.pc_o !== 32'h200) begin n_errors++; $display("FAIL ahb_next_pc: got %h exp 200", u_bus.pc_o); end
  endtask

  task automatic test_flush();
    flush_i = 5'b00001;
    u_bus.imem_ack_i = 1'b1; u_bus.imem_data_i = 32'h0060_0313;
    tick();
    flush_i = 5'b0; u_bus.imem_ack_i = 1'b0;
    n_checks++; if (u_bus.inst_o !== NOP) begin n_errors++; $display("FAIL flush_inst: got %h exp %h", u_bus.inst_o, NOP); end
    n_checks++; if (u_bus.pc_o !== 32'h200) begin n_errors++; $display("FAIL flush_pc: got %h exp 200", u_bus.pc_o); end
    tick();
    n_checks++; if (u_bus.inst_o !== 32'h0060_0313) begin n_errors++; $display("FAIL flush_deliver_inst: got %h exp 00600313", u_bus.inst_o); end
    n_checks++; if (u_bus.pc_o !== 32'h204) begin n_errors++; $display("FAIL flush_deliver_pc: got %h exp 204", u_bus.pc_o); end
    n_checks++; if (u_bus.imem_addr_o !== 32'h208) begin n_errors++; $display("FAIL flush_addr: got %h exp 208", u_bus.imem_addr_o); end
  endtask

  task automatic test_branch_from_hold();
    stall_i = 5'b00001;
    u_bus.imem_ack_i = 1'b1; u_bus.imem_data_i = 32'h1111_1111;
    tick();
    u_bus.imem_ack_i = 1'b0;
    branch_e_i = 1'b1; branch_addr_i = 32'h0000_0042;
    tick();
    branch_e_i = 1'b0; stall_i = 5'b0;
    n_checks++; if (u_bus.imem_addr_o !== 32'h40) begin n_errors++; $display("FAIL bhold_addr: got %h exp 40", u_bus.imem_addr_o); end
    n_checks++; if (u_bus.inst_o !== NOP) begin n_errors++; $display("FAIL bhold_inst: got %h exp %h", u_bus.inst_o, NOP); end
    u_bus.imem_ack_i = 1'b1; u_bus.imem_data_i = 32'h0070_0393;
    tick();
    u_bus.imem_ack_i = 1'b0;
    n_checks++; if (u_bus.inst_o !== 32'h0070_0393) begin n_errors++; $display("FAIL bhold_next_inst: got %h exp 00700393", u_bus.inst_o); end
    n_checks++; if (u_bus.pc_o !== 32'h40) begin n_errors++; $display("FAIL bhold_next_pc: got %h exp 40", u_bus.pc_o); end
  endtask

  task automatic test_reset_mid();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (u_bus.inst_o !== NOP) begin n_errors++; $display("FAIL mid_rst_inst: got %h exp %h", u_bus.inst_o, NOP); end
    n_checks++; if (u_bus.pc_o !== 32'h0) begin n_errors++; $display("FAIL mid_rst_pc: got %h exp 0", u_bus.pc_o); end
    n_checks++; if (u_bus.imem_addr_o !== 32'h0) begin n_errors++; $display("FAIL mid_rst_addr: got %h exp 0", u_bus.imem_addr_o); end
    n_checks++; if (u_bus.imem_req_o !== 1'b0) begin n_errors++; $display("FAIL mid_rst_req: got %b exp 0", u_bus.imem_req_o); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (u_bus.imem_req_o !== 1'b1) begin n_errors++; $display("FAIL mid_rst_first_req: got %b exp 1", u_bus.imem_req_o); end
    n_checks++; if (u_bus.imem_addr_o !== 32'h0) begin n_errors++; $display("FAIL mid_rst_first_addr: got %h exp 0", u_bus.imem_addr_o); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    stall_i = 5'b0;
    flush_i = 5'b0;
    branch_e_i = 1'b0;
    branch_addr_i = 32'h0;
    u_bus.imem_ack_i = 1'b0;
    u_bus.imem_data_i = 32'h0;
    #1;
    test_reset();
    test_stream();
    test_ack_delay();
    test_hold();
    test_branch_drain();
    test_ack_hold_branch();
    test_flush();
    test_branch_from_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
